// File: rtl/fsm_sar_pkg.sv
// Shared types for the SAR conversion sequencer: FSM state encoding and
// the channel-select width helper.
package fsm_sar_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_CONV,
      ST_ACCUM
   } state_e;

   // Mux-select width; a single channel still gets a 1-bit select.
   function automatic int unsigned cw_of(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fsm_sar_seq_search_core.sv
// Successive-approximation register with its bit pointer. load_i presets the
// MSB trial code; each step_i resolves the current bit and arms the next one.
module sar_search_core #(
   parameter int unsigned Width = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             cmp_i,
   output logic [Width-1:0] code_o,
   output logic             last_o
);

   localparam int unsigned PW = $clog2(Width);

   logic [Width-1:0] code_q, code_d;
   logic [PW-1:0]    ptr_q, ptr_d;

   always_comb begin
      code_d = code_q;
      ptr_d  = ptr_q;
      if (load_i) begin
         code_d            = '0;
         code_d[Width-1]   = 1'b1;
         ptr_d             = PW'(Width - 1);
      end else if (step_i) begin
         if (!cmp_i) code_d[ptr_q] = 1'b0;
         if (ptr_q != '0) begin
            code_d[ptr_q - 1'b1] = 1'b1;
            ptr_d                = ptr_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         code_q <= '0;
         ptr_q  <= '0;
      end else begin
         code_q <= code_d;
         ptr_q  <= ptr_d;
      end
   end

   assign code_o = code_q;
   assign last_o = (ptr_q == '0);

endmodule

// File: rtl/fsm_sar_seq.sv
// Multi-channel SAR ADC sequencer: scans the latched channel mask, runs one
// SAR search per conversion and averages 2^AvgLog2 conversions per channel.
module fsm_sar_seq
   import fsm_sar_pkg::*;
#(
   parameter int unsigned Width    = 6,
   parameter int unsigned Channels = 4,
   parameter int unsigned AvgLog2  = 0,
   localparam int unsigned CW      = cw_of(Channels)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                cont_i,
   input  logic [Channels-1:0] ch_mask_i,
   input  logic                cmp_i,
   output logic                sample_o,
   output logic [Width-1:0]    dac_o,
   output logic [CW-1:0]       ch_o,
   output logic [Width-1:0]    result_o,
   output logic [CW-1:0]       result_ch_o,
   output logic                valid_o,
   output logic                eoc_o,
   output logic                busy_o
);

   localparam int unsigned AW = Width + AvgLog2;
   localparam logic [AvgLog2:0] CNT_LAST = (AvgLog2 + 1)'((1 << AvgLog2) - 1);

   state_e              state_q, state_d;
   logic [Channels-1:0] mask_q, mask_d;
   logic [CW-1:0]       ch_q, ch_d;
   logic [AW-1:0]       acc_q, acc_d;
   logic [AvgLog2:0]    cnt_q, cnt_d;
   logic [Width-1:0]    result_q, result_d;
   logic [CW-1:0]       rch_q, rch_d;
   logic                valid_q, valid_d;
   logic                eoc_q, eoc_d;
   logic                sample_q, sample_d;
   logic                busy_q, busy_d;

   logic [Width-1:0]    code;
   logic                last;
   logic                load;
   logic                step;
   logic [AW-1:0]       acc_sum;
   logic [CW-1:0]       nxt_ch;
   logic                has_next;

   function automatic logic [CW-1:0] lowest(input logic [Channels-1:0] m);
      lowest = '0;
      for (int unsigned i = Channels; i > 0; i--) begin
         if (m[i-1]) lowest = CW'(i - 1);
      end
   endfunction

   // Next enabled channel strictly above the current one.
   always_comb begin
      nxt_ch   = '0;
      has_next = 1'b0;
      for (int unsigned i = Channels; i > 0; i--) begin
         if (mask_q[i-1] && ((i - 1) > 32'(ch_q))) begin
            nxt_ch   = CW'(i - 1);
            has_next = 1'b1;
         end
      end
   end

   assign acc_sum = acc_q + AW'(code);

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      ch_d     = ch_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      rch_d    = rch_q;
      valid_d  = 1'b0;
      eoc_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i && (ch_mask_i != '0)) begin
               state_d = ST_SAMPLE;
               mask_d  = ch_mask_i;
               ch_d    = lowest(ch_mask_i);
            end
         end
         ST_SAMPLE: state_d = ST_CONV;
         ST_CONV: begin
            if (last) state_d = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (cnt_q != CNT_LAST) begin
               acc_d   = acc_sum;
               cnt_d   = cnt_q + 1'b1;
               state_d = ST_SAMPLE;
            end else begin
               result_d = acc_sum[AvgLog2 +: Width];
               rch_d    = ch_q;
               valid_d  = 1'b1;
               acc_d    = '0;
               cnt_d    = '0;
               if (has_next) begin
                  ch_d    = nxt_ch;
                  state_d = ST_SAMPLE;
               end else begin
                  eoc_d = 1'b1;
                  if (cont_i) mask_d = ch_mask_i;
                  if (cont_i && (ch_mask_i != '0)) begin
                     ch_d    = lowest(ch_mask_i);
                     state_d = ST_SAMPLE;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      sample_d = (state_d == ST_SAMPLE);
      busy_d   = (state_d != ST_IDLE);
   end

   // The SAR is preset on the same edge that enters SAMPLE, so dac_o shows
   // the MSB trial code for the whole sample cycle.
   assign load = (state_d == ST_SAMPLE);
   assign step = (state_q == ST_CONV);

   sar_search_core #(
      .Width (Width)
   ) u_core (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .load_i (load),
      .step_i (step),
      .cmp_i  (cmp_i),
      .code_o (code),
      .last_o (last)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         mask_q   <= '0;
         ch_q     <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         rch_q    <= '0;
         valid_q  <= 1'b0;
         eoc_q    <= 1'b0;
         sample_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         ch_q     <= ch_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         rch_q    <= rch_d;
         valid_q  <= valid_d;
         eoc_q    <= eoc_d;
         sample_q <= sample_d;
         busy_q   <= busy_d;
      end
   end

   assign sample_o    = sample_q;
   assign dac_o       = code;
   assign ch_o        = ch_q;
   assign result_o    = result_q;
   assign result_ch_o = rch_q;
   assign valid_o     = valid_q;
   assign eoc_o       = eoc_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_fsm_sar_seq.sv
// Directed bench for fsm_sar_seq: one plain instance and one averaging
// instance, each driven by an ideal comparator model.
module tb_fsm_sar_seq;

   localparam int unsigned W  = 6;
   localparam int unsigned C  = 4;
   localparam int unsigned CW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, cont, cmp;
   logic [C-1:0]  mask;
   logic          sample, valid, eoc, busy;
   logic [W-1:0]  dac, result;
   logic [CW-1:0] ch, rch;
   logic [W-1:0]  vin [C];

   logic          start_a, cmp_a;
   logic [C-1:0]  mask_a;
   logic          sample_a, valid_a, eoc_a, busy_a;
   logic [W-1:0]  dac_a, result_a;
   logic [CW-1:0] ch_a, rch_a;
   logic          alt = 1'b0;

   assign cmp   = (vin[ch] >= dac);
   assign cmp_a = ((alt ? 6'd21 : 6'd20) >= dac_a);

   // Analog input of the averaging channel alternates between conversions.
   always @(posedge clk) if (sample_a) alt <= ~alt;

   fsm_sar_seq #(.Width(W), .Channels(C), .AvgLog2(0)) u_dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .cont_i(cont),
      .ch_mask_i(mask), .cmp_i(cmp), .sample_o(sample), .dac_o(dac),
      .ch_o(ch), .result_o(result), .result_ch_o(rch), .valid_o(valid),
      .eoc_o(eoc), .busy_o(busy)
   );

   fsm_sar_seq #(.Width(W), .Channels(C), .AvgLog2(2)) u_avg (
      .clk_i(clk), .rst_i(rst), .start_i(start_a), .cont_i(1'b0),
      .ch_mask_i(mask_a), .cmp_i(cmp_a), .sample_o(sample_a), .dac_o(dac_a),
      .ch_o(ch_a), .result_o(result_a), .result_ch_o(rch_a), .valid_o(valid_a),
      .eoc_o(eoc_a), .busy_o(busy_a)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   logic [W-1:0] t1_dac [6];
   int nv;

   initial begin
      t1_dac = '{6'd32, 6'd48, 6'd40, 6'd36, 6'd38, 6'd37};
      vin    = '{default: '0};
      rst = 1'b1; cont = 1'b0; start_a = 1'b0; mask_a = '0;
      // start held during reset must be overridden
      start = 1'b1; mask = 4'b0001;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_sample", sample, 0);
      chk("rst_dac", dac, 0);
      chk("rst_valid", valid, 0);
      chk("rst_result", result, 0);
      chk("rst_eoc", eoc, 0);
      chk("rst_avg_busy", busy_a, 0);

      // single channel, first edge out of reset accepts start
      vin[0] = 6'd37;
      rst = 1'b0;
      @(negedge clk);
      start = 1'b0; mask = '0;
      chk("t1_sample", sample, 1);
      chk("t1_busy", busy, 1);
      chk("t1_ch", ch, 0);
      chk("t1_dac_s", dac, 32);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("t1_dac%0d", i), dac, t1_dac[i]);
      end
      @(negedge clk);
      chk("t1_accum_valid", valid, 0);
      @(negedge clk);
      chk("t1_valid", valid, 1);
      chk("t1_result", result, 37);
      chk("t1_rch", rch, 0);
      chk("t1_eoc", eoc, 1);
      chk("t1_busy_end", busy, 0);
      @(negedge clk);
      chk("t1_valid_pulse", valid, 0);
      chk("t1_hold", result, 37);

      // two sparse channels; start/mask wiggled while busy are ignored
      vin[1] = 6'd0; vin[3] = 6'd63;
      start = 1'b1; mask = 4'b1010;
      @(negedge clk);
      chk("t2_ch_first", ch, 1);
      mask = 4'b0001;
      repeat (4) @(negedge clk);
      start = 1'b0; mask = '0;
      repeat (4) @(negedge clk);
      chk("t2_v1", valid, 1);
      chk("t2_r1", result, 0);
      chk("t2_c1", rch, 1);
      chk("t2_e1", eoc, 0);
      chk("t2_ch_next", ch, 3);
      chk("t2_resample", sample, 1);
      repeat (8) @(negedge clk);
      chk("t2_v3", valid, 1);
      chk("t2_r3", result, 63);
      chk("t2_c3", rch, 3);
      chk("t2_e3", eoc, 1);
      chk("t2_busy", busy, 0);
      @(negedge clk);
      chk("t2_idle", busy, 0);

      // continuous mode, then cont dropped mid-sequence
      vin[0] = 6'd10; vin[1] = 6'd50;
      cont = 1'b1; start = 1'b1; mask = 4'b0011;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("t3_v0", valid, 1);
      chk("t3_r0", result, 10);
      chk("t3_e0", eoc, 0);
      repeat (8) @(negedge clk);
      chk("t3_v1", valid, 1);
      chk("t3_r1", result, 50);
      chk("t3_c1", rch, 1);
      chk("t3_e1", eoc, 1);
      chk("t3_restart_busy", busy, 1);
      chk("t3_restart_ch", ch, 0);
      repeat (4) @(negedge clk);
      cont = 1'b0;
      repeat (4) @(negedge clk);
      chk("t3_v2", valid, 1);
      chk("t3_c2", rch, 0);
      chk("t3_e2", eoc, 0);
      repeat (8) @(negedge clk);
      chk("t3_e3", eoc, 1);
      chk("t3_c3", rch, 1);
      chk("t3_end_busy", busy, 0);
      @(negedge clk);
      chk("t3_idle", busy, 0);
      mask = '0;

      // reset during the third CONV cycle
      vin[0] = 6'd37;
      start = 1'b1; mask = 4'b0001;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("t4_conv3_dac", dac, 40);
      rst = 1'b1;
      @(negedge clk);
      chk("t4_busy", busy, 0);
      chk("t4_sample", sample, 0);
      chk("t4_dac", dac, 0);
      chk("t4_ch", ch, 0);
      chk("t4_result", result, 0);
      chk("t4_rch", rch, 0);
      chk("t4_valid", valid, 0);
      chk("t4_eoc", eoc, 0);
      rst = 1'b0; start = 1'b1; mask = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("t4_nomask_busy%0d", i), busy, 0);
         chk($sformatf("t4_nomask_dac%0d", i), dac, 0);
      end
      start = 1'b0;

      // averaging over four conversions on channel 2
      start_a = 1'b1; mask_a = 4'b0100;
      @(negedge clk);
      start_a = 1'b0; mask_a = '0;
      chk("t5_ch", ch_a, 2);
      chk("t5_sample", sample_a, 1);
      nv = 0;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         if (valid_a) nv++;
         if (i == 8) chk("t5_resample", sample_a, 1);
      end
      chk("t5_nvalid", nv, 1);
      chk("t5_valid", valid_a, 1);
      chk("t5_result", result_a, 20);
      chk("t5_rch", rch_a, 2);
      chk("t5_eoc", eoc_a, 1);
      chk("t5_busy", busy_a, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fsm_sar_seq.md
FSM_SAR_SEQ -- requirements
Module: fsm_sar_seq

Interface
REQ-001 Parameter Width, default 6: SAR code width in bits; legal range 2..16.
REQ-002 Parameter Channels, default 4: number of analog input channels; legal range 1..16.
REQ-003 Parameter AvgLog2, default 0: each result averages 2^AvgLog2 conversions; legal range 0..4.
REQ-004 clk_i  in  1  single clock; all logic on the rising edge.
REQ-005 rst_i  in  1  reset, synchronous and active-high.
REQ-006 start_i  in  1  level; starts a sequence when sampled high in IDLE.
REQ-007 cont_i  in  1  continuous mode; restart the sequence after the last channel.
REQ-008 ch_mask_i  in  Channels  enabled-channel mask; captured at start.
REQ-009 cmp_i  in  1  comparator output; 1 = input >= dac_o.
REQ-010 sample_o  out  1  sample/hold strobe.
REQ-011 dac_o  out  Width  trial DAC code.
REQ-012 ch_o  out  CW  analog mux select, CW = max(1, clog2(Channels)).
REQ-013 result_o  out  Width  averaged result; holds until the next valid_o.
REQ-014 result_ch_o  out  CW  channel of result_o.
REQ-015 valid_o  out  1  one-cycle pulse; result_o and result_ch_o are new.
REQ-016 eoc_o  out  1  one-cycle pulse at end of sequence.
REQ-017 busy_o  out  1  high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, SAMPLE, CONV, ACCUM.
REQ-019 IDLE to SAMPLE when start_i=1 and ch_mask_i!=0; the mask is latched and ch_o is set to the lowest set bit.
REQ-020 In IDLE with start_i=1 and ch_mask_i=0, the block SHALL stay in IDLE and no output SHALL change.
REQ-021 SAMPLE lasts 1 cycle with sample_o=1 and dac_o=2^(Width-1); sample_o SHALL be 0 in all other states.
REQ-022 CONV lasts exactly Width cycles, bit k from Width-1 down to 0; at each edge, bit k clears if cmp_i=0 and bit k-1 is set if k>0.
REQ-023 ACCUM lasts 1 cycle; the final code is added to an accumulator of Width+AvgLog2 bits, which cannot overflow.
REQ-024 Conversion latency SHALL be Width+2 cycles, from SAMPLE entry to ACCUM exit.
REQ-025 If fewer than 2^AvgLog2 conversions are done on the channel, ACCUM returns to SAMPLE on the same ch_o.
REQ-026 Otherwise, on the cycle after ACCUM: result_o = acc>>AvgLog2 (truncating), result_ch_o = ch_o, valid_o=1, and the accumulator and count clear.
REQ-027 After a result, ch_o advances to the next higher set bit of the latched mask and the block goes to SAMPLE.
REQ-028 After the highest set bit, eoc_o=1 in the same cycle as valid_o.
REQ-029 At end of sequence, cont_i=1 restarts SAMPLE at the lowest set bit, with the mask re-latched from ch_mask_i; if the new mask is 0, go to IDLE.
REQ-030 At end of sequence with cont_i=0, go to IDLE; cont_i is evaluated only at end of sequence.
REQ-031 start_i and ch_mask_i SHALL be ignored while busy_o=1.
REQ-032 When Channels=1, ch_o and result_ch_o SHALL be constant 0.

Reset
REQ-033 With rst_i=1 at an edge, from any state including mid-CONV: state=IDLE, all outputs 0, and accumulator, count and latched mask 0.
REQ-034 rst_i SHALL take priority over start_i in the same cycle.
REQ-035 The first start_i is accepted on the first edge with rst_i=0.

Structure
REQ-036 Package fsm_sar_pkg SHALL hold the state enum and a clog2-based CW helper function.
REQ-037 The successive-approximation register and bit pointer SHALL be one sub-module, sar_search_core (ports: clk_i, rst_i, load_i, step_i, cmp_i, code_o, last_o).
REQ-038 The sequencer, averaging and output registers SHALL reside in fsm_sar_seq.

Verification (Width=6, Channels=4, ideal comparator model unless stated)
REQ-039 AvgLog2=0, mask 0001, vin=37, start pulse -> dac_o sequence 32,48,40,36,38,37; valid_o 8 cycles after SAMPLE entry; result_o=37, result_ch_o=0, eoc_o=1.
REQ-040 mask 1010, vin1=0, vin3=63 -> valid_o with (0,ch1), then valid_o with (63,ch3) and eoc_o; then IDLE and busy_o=0.
REQ-041 AvgLog2=2, mask 0100, vin alternating 20,21 -> four conversions, result_o=20 (sum 82>>2), a single valid_o.
REQ-042 cont_i=1, mask 0011 -> eoc_o every 16 cycles; drop cont_i mid-sequence -> the current sequence completes, then IDLE.
REQ-043 rst_i asserted at the 3rd CONV cycle -> next cycle all outputs 0 and IDLE; start_i with mask 0 -> no activity.
